// File: rtl/pr_dispatch_sched.sv
// pr_dispatch_sched: in-order 3-way dispatch gating on free PRs, ROB and RS slots,
// plus sequencing of freelist head recovery after a branch mispredict.
module pr_dispatch_sched #(
  parameter int WAYS = 3,
  parameter int ROB_W = 5,
  parameter int CNT_W = 5,
  parameter int RECOVER_CYCLES = 2,
  parameter int STALL_W = 16
)(
  input  logic               clock,
  input  logic               reset,
  input  logic [WAYS-1:0]    dec_valid,
  input  logic [WAYS-1:0]    dec_has_dest,
  input  logic [CNT_W-1:0]   fl_free_cnt,
  input  logic [1:0]         rob_free,
  input  logic [1:0]         rs_free,
  input  logic               br_recover_en,
  input  logic [ROB_W-1:0]   br_recover_head,
  output logic [WAYS-1:0]    dispatch_grant,
  output logic [WAYS-1:0]    fl_dispatch_en,
  output logic               fl_recover_en,
  output logic [ROB_W-1:0]   fl_recover_head,
  output logic               sched_busy,
  output logic [STALL_W-1:0] stall_count
);
  typedef enum logic [1:0] {RUN, RECOVER, SETTLE} state_t;
  state_t state, state_nx;
  logic [2:0] rcnt, rcnt_nx;
  logic [CNT_W-1:0] dest;
  logic pre;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= RUN;
      rcnt <= '0;
      fl_recover_en <= 1'b0;
      fl_recover_head <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      rcnt <= rcnt_nx;
      fl_recover_en <= br_recover_en;
      fl_recover_head <= br_recover_en ? br_recover_head : fl_recover_head;
      if (state == RUN && !br_recover_en && dec_valid[0] && !dispatch_grant[0] && !(&stall_count))
        stall_count <= stall_count + 1'b1;
    end
  // A new request always restarts the sequence, even mid-recovery.
  always_comb begin
    state_nx = state;
    rcnt_nx = rcnt;
    if (br_recover_en) begin
      state_nx = RECOVER;
      rcnt_nx = 3'(RECOVER_CYCLES - 1);
    end else if (state == RECOVER) begin
      state_nx = rcnt == 3'd0 ? SETTLE : RECOVER;
      rcnt_nx = rcnt == 3'd0 ? rcnt : rcnt - 3'd1;
    end else if (state == SETTLE)
      state_nx = RUN;
  end
  // Running prefix: each way needs all older ways granted plus its own budget.
  always_comb begin
    dest = '0;
    pre = reset && state == RUN && !br_recover_en;
    dispatch_grant = '0;
    for (int i = 0; i < WAYS; i++) begin
      dest = dest + CNT_W'(dec_has_dest[i]);
      pre = pre && dec_valid[i] && dest <= fl_free_cnt && 2'(i + 1) <= rob_free && 2'(i + 1) <= rs_free;
      dispatch_grant[i] = pre;
    end
  end
  assign fl_dispatch_en = dispatch_grant & dec_has_dest;
  assign sched_busy = state != RUN;
endmodule

// File: tb/tb_pr_dispatch_sched.sv
// tb_pr_dispatch_sched: scoreboard bench; a cycle model pushes expected outputs,
// the negedge sampler pops and compares them against the DUT.
module tb_pr_dispatch_sched;
  localparam int RC = 2;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [2:0] dec_valid = '0, dec_has_dest = '0;
  logic [4:0] fl_free_cnt = '0;
  logic [1:0] rob_free = '0, rs_free = '0;
  logic br_recover_en = 1'b0;
  logic [4:0] br_recover_head = '0;
  logic [2:0] dispatch_grant, fl_dispatch_en;
  logic fl_recover_en, sched_busy;
  logic [4:0] fl_recover_head;
  logic [15:0] stall_count;
  int n_chk = 0, n_err = 0;
  typedef struct {
    logic [2:0] g;
    logic [2:0] fe;
    logic re;
    logic [4:0] hd;
    logic busy;
    logic [15:0] st;
  } exp_t;
  exp_t sb[$];
  int m_busy = 0;
  logic m_re = 1'b0;
  logic [4:0] m_hd = '0;
  logic [15:0] m_st = '0;
  pr_dispatch_sched #(.RECOVER_CYCLES(RC)) dut (
    .clock(clock), .reset(reset), .dec_valid(dec_valid), .dec_has_dest(dec_has_dest),
    .fl_free_cnt(fl_free_cnt), .rob_free(rob_free), .rs_free(rs_free),
    .br_recover_en(br_recover_en), .br_recover_head(br_recover_head),
    .dispatch_grant(dispatch_grant), .fl_dispatch_en(fl_dispatch_en),
    .fl_recover_en(fl_recover_en), .fl_recover_head(fl_recover_head),
    .sched_busy(sched_busy), .stall_count(stall_count)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic logic [2:0] m_grant();
    int n = 0, d = 0;
    logic [3:0] m;
    if (!reset || m_busy != 0 || br_recover_en) return 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (!dec_valid[k]) break;
      d += int'(dec_has_dest[k]);
      if (d > int'(fl_free_cnt) || k + 1 > int'(rob_free) || k + 1 > int'(rs_free)) break;
      n = k + 1;
    end
    m = (4'd1 << n) - 4'd1;
    return m[2:0];
  endfunction
  task automatic cycle();
    exp_t e, o;
    logic [2:0] g;
    g = m_grant();
    e.g = g; e.fe = g & dec_has_dest; e.re = m_re; e.hd = m_hd;
    e.busy = m_busy != 0; e.st = m_st;
    sb.push_back(e);
    @(negedge clock);
    o = sb.pop_front();
    check("grant", 32'(dispatch_grant), 32'(o.g));
    check("fl_dispatch_en", 32'(fl_dispatch_en), 32'(o.fe));
    check("fl_recover_en", 32'(fl_recover_en), 32'(o.re));
    check("fl_recover_head", 32'(fl_recover_head), 32'(o.hd));
    check("sched_busy", 32'(sched_busy), 32'(o.busy));
    check("stall_count", 32'(stall_count), 32'(o.st));
    @(posedge clock);
    if (!reset) begin
      m_busy = 0; m_re = 1'b0; m_hd = '0; m_st = '0;
    end else begin
      if (m_busy == 0 && !br_recover_en && dec_valid[0] && !g[0] && m_st != 16'hFFFF) m_st++;
      m_re = br_recover_en;
      if (br_recover_en) m_hd = br_recover_head;
      m_busy = br_recover_en ? RC + 1 : (m_busy > 0 ? m_busy - 1 : 0);
    end
    #1;
  endtask
  task automatic drive(input logic [2:0] v, input logic [2:0] h, input logic [4:0] f,
                       input logic [1:0] ro, input logic [1:0] rs, input logic br, input logic [4:0] hd);
    dec_valid = v; dec_has_dest = h; fl_free_cnt = f; rob_free = ro; rs_free = rs;
    br_recover_en = br; br_recover_head = hd;
    cycle();
  endtask
  initial begin
    drive(3'b111, 3'b111, 5'd10, 2'd3, 2'd3, 1'b0, 5'd0);
    drive(3'b111, 3'b111, 5'd10, 2'd3, 2'd3, 1'b0, 5'd0);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    drive(3'b111, 3'b111, 5'd10, 2'd3, 2'd3, 1'b0, 5'd0);
    drive(3'b111, 3'b011, 5'd1, 2'd3, 2'd3, 1'b0, 5'd0);
    drive(3'b111, 3'b101, 5'd1, 2'd3, 2'd3, 1'b0, 5'd0);
    drive(3'b111, 3'b111, 5'd3, 2'd3, 2'd3, 1'b0, 5'd0);
    drive(3'b111, 3'b000, 5'd0, 2'd2, 2'd3, 1'b0, 5'd0);
    drive(3'b111, 3'b000, 5'd9, 2'd3, 2'd1, 1'b0, 5'd0);
    drive(3'b101, 3'b000, 5'd9, 2'd3, 2'd3, 1'b0, 5'd0);
    drive(3'b110, 3'b000, 5'd9, 2'd3, 2'd3, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) drive(3'b001, 3'b001, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0);
    drive(3'b111, 3'b111, 5'd10, 2'd3, 2'd3, 1'b1, 5'd17);
    for (int i = 0; i < 5; i++) drive(3'b111, 3'b111, 5'd10, 2'd3, 2'd3, 1'b0, 5'd0);
    drive(3'b111, 3'b111, 5'd10, 2'd3, 2'd3, 1'b1, 5'd4);
    drive(3'b111, 3'b111, 5'd10, 2'd3, 2'd3, 1'b0, 5'd0);
    drive(3'b111, 3'b111, 5'd10, 2'd3, 2'd3, 1'b1, 5'd9);
    for (int i = 0; i < 5; i++) drive(3'b111, 3'b111, 5'd10, 2'd3, 2'd3, 1'b0, 5'd0);
    for (int i = 0; i < 60; i++)
      drive(3'($urandom), 3'($urandom), 5'($urandom_range(0, 4)), 2'($urandom), 2'($urandom),
            $urandom_range(0, 7) == 0, 5'($urandom));
    drive(3'b111, 3'b111, 5'd10, 2'd3, 2'd3, 1'b1, 5'd21);
    reset = 1'b0;
    #1;
    check("async_recover_en", 32'(fl_recover_en), 32'd0);
    check("async_busy", 32'(sched_busy), 32'd0);
    check("async_grant", 32'(dispatch_grant), 32'd0);
    check("async_stall", 32'(stall_count), 32'd0);
    m_busy = 0; m_re = 1'b0; m_hd = '0; m_st = '0;
    drive(3'b111, 3'b111, 5'd10, 2'd3, 2'd3, 1'b0, 5'd0);
    reset = 1'b1;
    drive(3'b111, 3'b111, 5'd10, 2'd3, 2'd3, 1'b0, 5'd0);
    drive(3'b011, 3'b011, 5'd2, 2'd3, 2'd3, 1'b0, 5'd0);
    for (int i = 0; i < 30; i++)
      drive(3'($urandom), 3'($urandom), 5'($urandom_range(0, 4)), 2'($urandom), 2'($urandom),
            $urandom_range(0, 5) == 0, 5'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
